// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, E_Control field positions and the
// alu_control / pcselect1 encodings used by the execute stage.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   localparam int unsigned EC_ALU_HI    = 5;
   localparam int unsigned EC_ALU_LO    = 4;
   localparam int unsigned EC_PCSEL1_HI = 3;
   localparam int unsigned EC_PCSEL1_LO = 2;
   localparam int unsigned EC_PCSEL2    = 1;
   localparam int unsigned EC_OP2SEL    = 0;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_AND = 2'd1,
      ALU_NOT = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      PCS1_OFF11 = 2'd0,
      PCS1_OFF9  = 2'd1,
      PCS1_OFF6  = 2'd2,
      PCS1_ZERO  = 2'd3
   } pcsel1_e;

   function automatic logic writes_dr(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
             (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
             (op == OP_LEA);
   endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU for the execute stage: ADD / AND / NOT with the
// second operand chosen between register B and the 5-bit immediate.
module execute_alu
   import lc3_pkg::*;
(
   input  logic [1:0]  alu_control,
   input  logic        op2select,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [4:0]  imm5,
   output logic [15:0] result
);

   logic [15:0] op2;

   always_comb begin
      op2    = op2select ? op_b : {{11{imm5[4]}}, imm5};
      result = '0;
      case (alu_op_e'(alu_control))
         ALU_ADD: result = op_a + op2;
         ALU_AND: result = op_a & op2;
         ALU_NOT: result = ~op_a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/execute.sv
// LC-3 execute stage: operand forwarding, ALU, address generation and the
// execute/writeback pipeline register bank.
module execute
   import lc3_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable_execute,
   input  logic [5:0]  E_Control,
   input  logic        Mem_Control_in,
   input  logic [1:0]  W_Control_in,
   input  logic [15:0] IR,
   input  logic [15:0] npc,
   input  logic [15:0] VSR1,
   input  logic [15:0] VSR2,
   input  logic        bypass_alu_1,
   input  logic        bypass_alu_2,
   input  logic        bypass_mem_1,
   input  logic        bypass_mem_2,
   input  logic [15:0] Mem_Bypass_Val,
   output logic [15:0] aluout,
   output logic [15:0] pcout,
   output logic [15:0] M_Data,
   output logic [15:0] IR_Exec,
   output logic [2:0]  dr,
   output logic [2:0]  NZP,
   output logic [1:0]  W_Control_out,
   output logic        Mem_Control_out,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2
);

   logic [3:0]  opcode;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] alu_result;
   logic [15:0] offset;
   logic [15:0] base;
   logic [15:0] address;

   assign opcode = IR[15:12];
   assign sr1    = IR[8:6];

   always_comb begin
      sr2 = '0;
      case (opcode)
         OP_ST, OP_STR, OP_STI: sr2 = IR[11:9];
         OP_ADD, OP_AND:        sr2 = IR[2:0];
         default:               sr2 = '0;
      endcase
   end

   // Forwarding uses the registered aluout, i.e. the previous instruction's result.
   always_comb begin
      op_a = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
      op_b = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
   end

   always_comb begin
      offset = '0;
      case (pcsel1_e'(E_Control[EC_PCSEL1_HI:EC_PCSEL1_LO]))
         PCS1_OFF11: offset = {{5{IR[10]}}, IR[10:0]};
         PCS1_OFF9:  offset = {{7{IR[8]}}, IR[8:0]};
         PCS1_OFF6:  offset = {{10{IR[5]}}, IR[5:0]};
         default:    offset = '0;
      endcase
      base    = E_Control[EC_PCSEL2] ? npc : VSR1;
      address = base + offset;
   end

   execute_alu u_alu (
      .alu_control (E_Control[EC_ALU_HI:EC_ALU_LO]),
      .op2select   (E_Control[EC_OP2SEL]),
      .op_a        (op_a),
      .op_b        (op_b),
      .imm5        (IR[4:0]),
      .result      (alu_result)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         aluout          <= '0;
         pcout           <= '0;
         M_Data          <= '0;
         IR_Exec         <= '0;
         dr              <= '0;
         NZP             <= '0;
         W_Control_out   <= '0;
         Mem_Control_out <= '0;
      end else if (enable_execute) begin
         aluout          <= (opcode == OP_LEA) ? address : alu_result;
         pcout           <= address;
         M_Data          <= op_b;
         IR_Exec         <= IR;
         dr              <= writes_dr(opcode) ? IR[11:9] : '0;
         NZP             <= (opcode == OP_BR)  ? IR[11:9] :
                            (opcode == OP_JMP) ? 3'b111   : 3'b000;
         W_Control_out   <= W_Control_in;
         Mem_Control_out <= Mem_Control_in;
      end
   end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed cases plus randomized traffic
// compared against an arithmetic reference model of the stage.
module tb_execute;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable_execute;
   logic [5:0]  E_Control;
   logic        Mem_Control_in;
   logic [1:0]  W_Control_in;
   logic [15:0] IR, npc, VSR1, VSR2, Mem_Bypass_Val;
   logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
   logic [15:0] aluout, pcout, M_Data, IR_Exec;
   logic [2:0]  dr, NZP, sr1, sr2;
   logic [1:0]  W_Control_out;
   logic        Mem_Control_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_aluout, m_pcout, m_mdata, m_ir;
   logic [2:0]  m_dr, m_nzp;
   logic [1:0]  m_wc;
   logic        m_mc;

   execute dut (
      .clock(clock), .reset_n(reset_n), .enable_execute(enable_execute),
      .E_Control(E_Control), .Mem_Control_in(Mem_Control_in),
      .W_Control_in(W_Control_in), .IR(IR), .npc(npc), .VSR1(VSR1), .VSR2(VSR2),
      .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
      .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
      .Mem_Bypass_Val(Mem_Bypass_Val), .aluout(aluout), .pcout(pcout),
      .M_Data(M_Data), .IR_Exec(IR_Exec), .dr(dr), .NZP(NZP),
      .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
      .sr1(sr1), .sr2(sr2)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Interpret the low `bits` of v as a two's-complement number.
   function automatic int sx(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   task automatic check_regs(input string tag);
      check({tag, ".aluout"}, aluout, m_aluout);
      check({tag, ".pcout"},  pcout,  m_pcout);
      check({tag, ".M_Data"}, M_Data, m_mdata);
      check({tag, ".IR_Exec"}, IR_Exec, m_ir);
      check({tag, ".dr"},  16'(dr),  16'(m_dr));
      check({tag, ".NZP"}, 16'(NZP), 16'(m_nzp));
      check({tag, ".W_Control_out"},   16'(W_Control_out),   16'(m_wc));
      check({tag, ".Mem_Control_out"}, 16'(Mem_Control_out), 16'(m_mc));
   endtask

   task automatic model_clear();
      m_aluout = '0; m_pcout = '0; m_mdata = '0; m_ir = '0;
      m_dr = '0; m_nzp = '0; m_wc = '0; m_mc = 1'b0;
   endtask

   // Inputs are already driven; check sources, clock once, check registers.
   task automatic cycle(input string tag);
      int op, rd, off, exp_sr2;
      logic [15:0] a, b, op2, res, base, addr;
      op = int'(IR[15:12]);
      rd = int'(IR[11:9]);
      exp_sr2 = (op == 3 || op == 7 || op == 11) ? rd :
                (op == 1 || op == 5) ? int'(IR[2:0]) : 0;
      #1;
      check({tag, ".sr1"}, 16'(sr1), 16'(IR[8:6]));
      check({tag, ".sr2"}, 16'(sr2), 16'(exp_sr2));
      a   = bypass_alu_1 ? m_aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
      b   = bypass_alu_2 ? m_aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
      op2 = E_Control[0] ? b : 16'(sx(int'(IR[4:0]), 5));
      case (E_Control[5:4])
         2'd0:    res = a + op2;
         2'd1:    res = a & op2;
         2'd2:    res = ~a;
         default: res = 16'h0;
      endcase
      case (E_Control[3:2])
         2'd0:    off = sx(int'(IR[10:0]), 11);
         2'd1:    off = sx(int'(IR[8:0]), 9);
         2'd2:    off = sx(int'(IR[5:0]), 6);
         default: off = 0;
      endcase
      base = E_Control[1] ? npc : VSR1;
      addr = 16'(int'(base) + off);
      @(posedge clock);
      if (enable_execute && reset_n) begin
         m_aluout = (op == 14) ? addr : res;
         m_pcout  = addr;
         m_mdata  = b;
         m_ir     = IR;
         m_dr     = (op == 1 || op == 5 || op == 9 || op == 2 || op == 6 ||
                     op == 10 || op == 14) ? IR[11:9] : 3'b000;
         m_nzp    = (op == 0) ? IR[11:9] : (op == 12) ? 3'b111 : 3'b000;
         m_wc     = W_Control_in;
         m_mc     = Mem_Control_in;
      end
      #1;
      check_regs(tag);
      @(negedge clock);
   endtask

   task automatic drive(input logic [15:0] ir_v, input logic [5:0] ec,
                        input logic [15:0] v1, input logic [15:0] v2,
                        input logic [15:0] pc);
      IR = ir_v; E_Control = ec; VSR1 = v1; VSR2 = v2; npc = pc;
   endtask

   task automatic drive_random();
      IR             = 16'($urandom);
      E_Control      = {2'($urandom_range(0, 2)), 4'($urandom)};
      VSR1           = 16'($urandom);
      VSR2           = 16'($urandom);
      npc            = 16'($urandom);
      Mem_Bypass_Val = 16'($urandom);
      {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = 4'($urandom);
      Mem_Control_in = 1'($urandom);
      W_Control_in   = 2'($urandom);
   endtask

   initial begin
      reset_n = 1'b0; enable_execute = 1'b1;
      drive(16'h0, 6'b0, 16'h0, 16'h0, 16'h0);
      Mem_Bypass_Val = '0; Mem_Control_in = 1'b0; W_Control_in = '0;
      {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = '0;
      model_clear();
      @(negedge clock);
      @(negedge clock);
      check_regs("reset");
      reset_n = 1'b1;

      drive(16'h1042, 6'b000001, 16'd5, 16'd7, 16'h3000);
      cycle("add_reg");
      check("add_reg.aluout12", aluout, 16'd12);

      drive(16'h127F, 6'b000000, 16'd3, 16'd99, 16'h3000);
      cycle("add_imm");
      check("add_imm.aluout2", aluout, 16'd2);
      check("add_imm.dr1", 16'(dr), 16'd1);

      drive(16'h1042, 6'b000001, 16'd4, 16'd5, 16'h3000);
      cycle("pre_bypass");
      bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1; Mem_Bypass_Val = 16'd4;
      drive(16'h1042, 6'b000001, 16'd100, 16'd1, 16'h3000);
      cycle("bypass_prio");
      check("bypass_prio.aluout10", aluout, 16'd10);
      bypass_alu_1 = 1'b0; bypass_mem_1 = 1'b0;

      drive(16'h0C05, 6'b000110, 16'h0, 16'h0, 16'h3001);
      cycle("brnz");
      check("brnz.pcout", pcout, 16'h3006);
      check("brnz.nzp", 16'(NZP), 16'b110);

      enable_execute = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_random();
         cycle("hold");
      end
      check("hold.pcout_kept", pcout, 16'h3006);
      enable_execute = 1'b1;

      drive(16'h1042, 6'b000001, 16'd1, 16'd2, 16'h3000);
      cycle("pre_reset");
      drive_random();
      #2 reset_n = 1'b0;
      #1;
      model_clear();
      check_regs("reset_mid");
      @(posedge clock);
      #1;
      check_regs("reset_hold");
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         drive_random();
         enable_execute = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port enable_execute, input, 1 bit: register-update enable.
REQ-004 SHALL have port E_Control, input, 6 bits, with fields:
- [5:4] alu_control: 0 ADD, 1 AND, 2 NOT.
- [3:2] pcselect1: 0 sext(IR[10:0]), 1 sext(IR[8:0]), 2 sext(IR[5:0]), 3 zero.
- [1] pcselect2: 1 npc, 0 VSR1.
- [0] op2select: 1 VSR2, 0 sext(IR[4:0]).
REQ-005 SHALL have port Mem_Control_in, input, 1 bit: memory control passed through to Mem_Control_out.
REQ-006 SHALL have port W_Control_in, input, 2 bits: writeback control passed through to W_Control_out.
REQ-007 SHALL have port IR, input, 16 bits: instruction from decode.
REQ-008 SHALL have port npc, input, 16 bits: next PC from decode.
REQ-009 SHALL have ports VSR1 and VSR2, input, 16 bits each: register-file read values.
REQ-010 SHALL have bypass selects bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, input, 1 bit each.
REQ-011 SHALL have port Mem_Bypass_Val, input, 16 bits: forwarded memory-stage value.
REQ-012 SHALL have registered outputs:
- aluout, pcout, M_Data, IR_Exec: 16 bits.
- dr: 3 bits; NZP: 3 bits; W_Control_out: 2 bits; Mem_Control_out: 1 bit.
REQ-013 SHALL have combinational outputs sr1 and sr2, 3 bits each.

Function
REQ-014 SHALL form operand A as:
- aluout (the registered value) if bypass_alu_1;
- else Mem_Bypass_Val if bypass_mem_1;
- else VSR1.
REQ-015 SHALL form operand B the same way from bypass_alu_2, bypass_mem_2 and VSR2; alu bypass wins when both selects are high.
REQ-016 SHALL compute the ALU result as:
- ADD: A + op2, modulo 2^16, carry discarded.
- AND: A & op2.
- NOT: ~A.
- op2 is B or sext(IR[4:0]) per op2select.
REQ-017 SHALL compute the address as pcselect2 operand + pcselect1 offset, modulo 2^16.
REQ-018 SHALL, on a rising edge with enable_execute=1, register:
- aluout <= ALU result, or the address when IR[15:12]=LEA (1110).
- pcout <= address.
- M_Data <= operand B.
- IR_Exec <= IR.
- W_Control_out <= W_Control_in; Mem_Control_out <= Mem_Control_in.
REQ-019 SHALL register dr <= IR[11:9] for ADD, AND, NOT, LD, LDR, LDI and LEA, and dr <= 0 otherwise.
REQ-020 SHALL register NZP <= IR[11:9] for BR (0000), 3'b111 for JMP (1100), and 0 otherwise.
REQ-021 SHALL hold every registered output unchanged while enable_execute=0; there is no partial update.
REQ-022 SHALL have a latency of one clock from inputs to registered outputs.
REQ-023 SHALL drive sr1 = IR[8:6] combinationally.
REQ-024 SHALL drive sr2 combinationally as:
- IR[11:9] for ST, STR and STI;
- IR[2:0] for ADD and AND;
- 0 otherwise.
REQ-025 SHALL base bypass_alu on the pre-edge aluout, so back-to-back dependent ADDs use the previous result.

Reset
REQ-026 SHALL clear all registered outputs to 0 immediately when reset_n=0, regardless of clock or enable.
REQ-027 SHALL resume at the first rising edge with reset_n=1 and enable_execute=1; a reset mid-instruction discards that instruction.

Structure
REQ-028 SHALL take opcode constants, E_Control field positions, and alu_control/pcselect1 encodings from a shared lc3 package.
REQ-029 SHALL contain one combinational sub-module, execute_alu, implementing REQ-016.

Verification
REQ-030 SHALL cover ADD register form: IR=16'h1042, VSR1=5, VSR2=7, E_Control=6'b000001, enable=1 -> aluout=12, dr=0 next cycle.
REQ-031 SHALL cover ADD immediate: IR=16'h127F, VSR1=3, op2select=0 -> aluout=2 (3 + -1), dr=1.
REQ-032 SHALL cover bypass priority: bypass_alu_1=bypass_mem_1=1, prior aluout=9, Mem_Bypass_Val=4 -> operand A=9.
REQ-033 SHALL cover BRnz: IR=16'h0C05, npc=16'h3001, E_Control=6'b000110 -> pcout=16'h3006, NZP=3'b110.
REQ-034 SHALL cover hold: enable_execute=0 for 3 cycles with changing inputs -> all outputs unchanged.
REQ-035 SHALL cover reset mid-operation: reset_n pulsed low between clock edges -> all outputs 0 before the next edge.
